// File: rtl/ultra_sequencer.sv
// Measurement sequencer for the ultrasonic sensor: clears the echo counter, fires TRIGGER,
// waits for the echo (bounded by a timeout), latches the result and spaces measurements apart.
module ultra_sequencer #(
    parameter int unsigned TRIG_CYCLES    = 10,
    parameter int unsigned TIMEOUT_CYCLES = 4000,
    parameter int unsigned HOLDOFF_CYCLES = 6000
) (
    input  logic       CLKOUT,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] count_in,
    input  logic       calculate_in,
    output logic       TRIGGER,
    output logic       counter_reset,
    output logic [7:0] distance,
    output logic       valid,
    output logic       timeout,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        TRIG,
        WAIT,
        HOLDOFF
    } state_t;

    localparam logic [15:0] TRIG_LOAD    = 16'(TRIG_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0] HOLD_LOAD    = 16'(HOLDOFF_CYCLES - 1);

    state_t      state;
    state_t      next_state;
    logic [15:0] timer;
    logic [15:0] next_timer;
    logic        done;
    logic        echo;

    // TRIG and HOLDOFF count down to zero; WAIT counts up so the timeout compare is a constant.
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        next_state = state;
        next_timer = timer;
        done       = 1'b0;
        echo       = 1'b0;
        case (state)
            IDLE: begin
                if (enable) next_state = CLEAR;
            end
            CLEAR: begin
                next_state = TRIG;
                next_timer = TRIG_LOAD;
            end
            TRIG: begin
                if (timer == 16'd0) begin
                    next_state = WAIT;
                    next_timer = 16'd0;
                end else begin
                    next_timer = timer - 16'd1;
                end
            end
            WAIT: begin
                next_timer = timer + 16'd1;
                // An echo arriving on the timeout cycle still counts as a real result.
                if (calculate_in) begin
                    done       = 1'b1;
                    echo       = 1'b1;
                    next_state = HOLDOFF;
                    next_timer = HOLD_LOAD;
                end else if (timer == TIMEOUT_LAST) begin
                    done       = 1'b1;
                    next_state = HOLDOFF;
                    next_timer = HOLD_LOAD;
                end
            end
            HOLDOFF: begin
                if (timer == 16'd0) begin
                    next_state = enable ? CLEAR : IDLE;
                end else begin
                    next_timer = timer - 16'd1;
                end
            end
            default: begin
                next_state = IDLE;
                next_timer = 16'd0;
            end
        endcase
    end

    // Outputs are registered from next_state so they line up with the state they describe.
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge CLKOUT or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            timer         <= 16'd0;
            TRIGGER       <= 1'b0;
            counter_reset <= 1'b1;
            distance      <= 8'h00;
            valid         <= 1'b0;
            timeout       <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state         <= next_state;
            timer         <= next_timer;
            TRIGGER       <= (next_state == TRIG);
            counter_reset <= (next_state == IDLE) || (next_state == CLEAR) || (next_state == HOLDOFF);
            busy          <= (next_state != IDLE);
            valid         <= done;
            if (done) begin
                distance <= echo ? count_in : 8'hFF;
                timeout  <= !echo;
            end
        end
    end

endmodule

// File: tb/tb_ultra_sequencer.sv
// Directed bench for ultra_sequencer: a table of echo scenarios with hand-computed results,
// plus hand-written sequences for reset, enable drop and mid-measurement reset.
module tb_ultra_sequencer;

    localparam int T_CYC = 10;
    localparam int TO_CYC = 300;
    localparam int H_CYC = 50;

    logic       CLKOUT;
    logic       reset;
    logic       enable;
    logic [7:0] count_in;
    logic       calculate_in;
    logic       TRIGGER;
    logic       counter_reset;
    logic [7:0] distance;
    logic       valid;
    logic       timeout;
    logic       busy;

    ultra_sequencer #(
        .TRIG_CYCLES   (T_CYC),
        .TIMEOUT_CYCLES(TO_CYC),
        .HOLDOFF_CYCLES(H_CYC)
    ) dut (
        .CLKOUT       (CLKOUT),
        .reset        (reset),
        .enable       (enable),
        .count_in     (count_in),
        .calculate_in (calculate_in),
        .TRIGGER      (TRIGGER),
        .counter_reset(counter_reset),
        .distance     (distance),
        .valid        (valid),
        .timeout      (timeout),
        .busy         (busy)
    );

    initial begin
        CLKOUT = 1'b0;
        forever #5 CLKOUT = ~CLKOUT;
    end

    int n_vec = 0;
    int n_err = 0;
    int valid_cnt = 0;
    int v_start = 0;

    // Counts valid pulses one time unit after each rising edge.
    always @(posedge CLKOUT) begin
        #1;
        if (valid) valid_cnt++;
    end

    // {TRIGGER, counter_reset, distance, valid, timeout, busy}
    localparam logic [12:0] RESET_PAT = {1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [12:0] out_pat();
        return {TRIGGER, counter_reset, distance, valid, timeout, busy};
    endfunction

    // From IDLE with enable high: one CLEAR cycle, then TRIGGER rises on the second edge.
    task automatic start_from_idle(input string tag);
        @(negedge CLKOUT);
        check({tag, " clear"}, {28'd0, TRIGGER, counter_reset, valid, busy}, 32'b0101);
        @(negedge CLKOUT);
        check({tag, " trig rise"}, {30'd0, TRIGGER, counter_reset}, 32'b10);
    endtask

    // Entered on the first TRIG negedge; returns on the negedge where valid is seen.
    task automatic measure(input string tag, input int w, input logic [7:0] cnt,
                           input logic [7:0] exp_d, input logic exp_to, input int exp_lat);
        int len;
        int lat;
        bit found;
        v_start = valid_cnt;
        len = 0;
        while (TRIGGER && len < 100) begin
            len++;
            @(negedge CLKOUT);
        end
        check({tag, " trig len"}, len, T_CYC);
        lat = 0;
        found = 0;
        while (!found && lat < TO_CYC + 20) begin
            if (lat == 0) count_in = cnt;
            if (lat == w) calculate_in = 1'b1;
            @(negedge CLKOUT);
            lat++;
            if (valid) found = 1;
        end
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " distance"}, distance, exp_d);
        check({tag, " timeout"}, timeout, exp_to);
        check({tag, " holdoff flags"}, {29'd0, counter_reset, busy, TRIGGER}, 32'b110);
        calculate_in = 1'b0;
    endtask

    // Continuous mode: HOLDOFF, CLEAR, then the next TRIGGER; ends on its first high negedge.
    task automatic holdoff_to_next(input string tag, input logic [7:0] exp_d);
        int g;
        g = 0;
        while (!TRIGGER && g < H_CYC + 20) begin
            @(negedge CLKOUT);
            g++;
            if (g == 1) check({tag, " valid width"}, valid, 1'b0);
        end
        check({tag, " gap"}, g, H_CYC + 1);
        check({tag, " distance held"}, distance, exp_d);
        check({tag, " valid count"}, valid_cnt - v_start, 1);
    endtask

    typedef struct {
        string      name;
        int         echo_at;
        logic [7:0] count;
        logic [7:0] exp_dist;
        logic       exp_to;
        int         exp_lat;
    } vec_t;

    vec_t vecs[5];

    initial begin
        bit saw_trig;
        int v0;

        vecs[0] = '{"echo120", 120, 8'd87,  8'd87,  1'b0, 121};
        vecs[1] = '{"noecho",  -1,  8'h55,  8'hFF,  1'b1, 300};
        vecs[2] = '{"echo5",   5,   8'd42,  8'd42,  1'b0, 6};
        vecs[3] = '{"tie299",  299, 8'd200, 8'd200, 1'b0, 300};
        vecs[4] = '{"echo0",   0,   8'd0,   8'd0,   1'b0, 1};

        reset = 1'b0;
        enable = 1'b1;
        count_in = 8'd0;
        calculate_in = 1'b0;

        repeat (5) begin
            @(negedge CLKOUT);
            check("reset outputs", out_pat(), RESET_PAT);
        end
        reset = 1'b1;
        start_from_idle("post reset");

        foreach (vecs[i]) begin
            measure(vecs[i].name, vecs[i].echo_at, vecs[i].count,
                    vecs[i].exp_dist, vecs[i].exp_to, vecs[i].exp_lat);
            holdoff_to_next(vecs[i].name, vecs[i].exp_dist);
        end

        // Drop enable during TRIG: the measurement still completes, then the block idles.
        enable = 1'b0;
        measure("en drop", 10, 8'd33, 8'd33, 1'b0, 11);
        v0 = valid_cnt;
        saw_trig = 0;
        for (int i = 1; i <= H_CYC + 20; i++) begin
            @(negedge CLKOUT);
            if (TRIGGER) saw_trig = 1;
            if (i == H_CYC - 1) check("en drop last holdoff busy", busy, 1'b1);
            if (i == H_CYC) check("en drop idle flags", {30'd0, busy, counter_reset}, 32'b01);
        end
        check("en drop no retrigger", saw_trig, 1'b0);
        check("en drop idle busy", busy, 1'b0);
        check("en drop valid count", valid_cnt - v_start, 1);

        // Reset pulsed mid-WAIT aborts without a valid pulse.
        enable = 1'b1;
        start_from_idle("pre abort");
        begin
            int len;
            len = 0;
            while (TRIGGER && len < 100) begin
                len++;
                @(negedge CLKOUT);
            end
            check("pre abort trig len", len, T_CYC);
        end
        repeat (50) @(negedge CLKOUT);
        v0 = valid_cnt;
        #2 reset = 1'b0;
        #1 check("async reset outputs", out_pat(), RESET_PAT);
        repeat (3) begin
            @(negedge CLKOUT);
            check("held reset outputs", out_pat(), RESET_PAT);
        end
        check("abort valid count", valid_cnt - v0, 0);
        reset = 1'b1;
        start_from_idle("post abort");
        measure("post abort", 3, 8'd7, 8'd7, 1'b0, 4);
        holdoff_to_next("post abort", 8'd7);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/ultra_sequencer.md
Name: ultra_sequencer

Overview:
- Measurement controller for the ultrasonic peripheral. It sits beside the echo pulse counter: it drives the counter's clear and consumes the counter's count/calculate outputs.
- It generates the sensor TRIGGER pulse and bounds each measurement with a timeout.
- It latches each finished echo count as the distance result, flagged by a one-cycle valid strobe.
- It runs back-to-back measurements while enable is high, separated by a holdoff gap.

Parameters:
- TRIG_CYCLES, 10, TRIGGER high time in CLKOUT cycles (1..65535).
- TIMEOUT_CYCLES, 4000, maximum WAIT duration before declaring no echo (2..65535).
- HOLDOFF_CYCLES, 6000, gap between the end of one measurement and the next clear (1..65535).

Ports:
- CLKOUT, input, 1, sensor tick clock; all logic on its rising edge.
- reset, input, 1, asynchronous active-low reset.
- enable, input, 1, level; high = run measurements continuously.
- count_in, input, 8, echo count from the pulse counter.
- calculate_in, input, 1, counter's echo-finished flag (sticky until the counter is cleared).
- TRIGGER, output, 1, sensor trigger pulse.
- counter_reset, output, 1, active-high clear to the pulse counter.
- distance, output, 8, latched result.
- valid, output, 1, one-cycle strobe: distance/timeout updated.
- timeout, output, 1, level; last result was a timeout.
- busy, output, 1, high in any state other than IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE; timer=0.
  - TRIGGER=0, counter_reset=1, distance=8'h00, valid=0, timeout=0, busy=0.
  - Reset asserted mid-measurement aborts it immediately: no valid pulse, distance unchanged from the reset value.
- All outputs are registered. One 16-bit down/up timer is shared by the TRIG, WAIT and HOLDOFF states.
- States and transitions:
  - IDLE: counter_reset=1, TRIGGER=0. If enable=1 at an edge, go to CLEAR.
  - CLEAR: exactly 1 cycle, counter_reset=1. Then go to TRIG.
  - TRIG: counter_reset=0, TRIGGER=1 for exactly TRIG_CYCLES cycles. Then go to WAIT with timer=0.
  - WAIT: counter_reset=0, TRIGGER=0; timer increments each cycle.
    - calculate_in=1 sampled: distance<=count_in, timeout<=0, valid=1 in the following cycle; go to HOLDOFF.
    - Else if timer==TIMEOUT_CYCLES-1: distance<=8'hFF, timeout<=1, valid=1 in the following cycle; go to HOLDOFF.
    - calculate_in=1 in the same cycle as the timeout condition: the echo result wins.
  - HOLDOFF: counter_reset=1, TRIGGER=0, lasts HOLDOFF_CYCLES cycles.
    - At exit, if enable=1 go to CLEAR, else go to IDLE.
- valid is high for exactly one cycle per completed measurement, coincident with the first HOLDOFF cycle. distance and timeout hold their values until the next valid.
- enable is sampled only in IDLE and at HOLDOFF exit. Deasserting it mid-measurement lets the current measurement finish and report.
- count_in is captured unmodified. Counter wrap past 255 is not corrected here; TIMEOUT_CYCLES is sized by integration so a wrap cannot precede the timeout.
- calculate_in is ignored outside WAIT.
- Cycle latency from enable rising in IDLE to TRIGGER rising: 2 edges (IDLE->CLEAR->TRIG).
- Measurement period with echo at W cycles into WAIT = 1 + TRIG_CYCLES + (W+1) + HOLDOFF_CYCLES.

Test Plan (bench parameters TRIG_CYCLES=10, TIMEOUT_CYCLES=300, HOLDOFF_CYCLES=50):
1. Reset held low 5 cycles with enable=1 -> TRIGGER=0, counter_reset=1, distance=0, valid=0, timeout=0, busy=0 throughout. After release: CLEAR, then TRIGGER high exactly 10 cycles.
2. Behavioural echo model: calculate_in rises 120 cycles into WAIT with count_in=8'd87 -> one valid pulse, distance=87, timeout=0. counter_reset high for 50 cycles, then the next TRIGGER begins.
3. No echo (calculate_in=0) -> valid at WAIT cycle 300, distance=8'hFF, timeout=1. Next successful measurement with count 42 -> distance=42, timeout=0.
4. calculate_in rises on the same cycle as timer==299 with count_in=8'd200 -> distance=200, timeout=0, single valid pulse.
5. enable dropped during TRIG -> measurement completes with one valid, HOLDOFF then IDLE, busy=0, no further TRIGGER.
6. reset pulsed low during WAIT -> outputs return to reset values immediately, no valid pulse. After release with enable=1, a fresh CLEAR/TRIG sequence starts.
